// File: rtl/grid_axis_streamer.sv
`default_nettype none
// grid_axis_streamer -- snapshots a WIDTH x HEIGHT cell grid on start and streams it
// as AXI4-Stream beats of CELLS_PER_BEAT cells (TUSER = start of frame).  Rev 1.0
module grid_axis_streamer #(
  parameter int CELL_WIDTH     = 1,
  parameter int WIDTH          = 32,
  parameter int HEIGHT         = 32,
  parameter int CELLS_PER_BEAT = 32,
  parameter int LAST_PER_ROW   = 0
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic                                  start,
  input  logic [WIDTH*HEIGHT*CELL_WIDTH-1:0]    frame,
  output logic                                  busy,
  output logic                                  done,
  output logic                                  M_AXIS_TVALID,
  input  logic                                  M_AXIS_TREADY,
  output logic [CELL_WIDTH*CELLS_PER_BEAT-1:0]  M_AXIS_TDATA,
  output logic                                  M_AXIS_TLAST,
  output logic                                  M_AXIS_TUSER
);

  localparam int DWIDTH        = CELL_WIDTH * CELLS_PER_BEAT;
  localparam int FWIDTH        = WIDTH * HEIGHT * CELL_WIDTH;
  localparam int BEATS_PER_ROW = WIDTH / CELLS_PER_BEAT;
  localparam int TOTAL_BEATS   = HEIGHT * BEATS_PER_ROW;
  localparam int CNT_W         = (TOTAL_BEATS > 1) ? $clog2(TOTAL_BEATS) : 1;

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    STREAM = 1'b1
  } state_t;

  state_t            state;
  state_t            state_next;
  logic [CNT_W-1:0]  cnt;
  logic [FWIDTH-1:0] snap;
  logic              done_q;
  logic              xfer;
  logic              last_beat;
  logic              tlast_sel;

  assign xfer      = (state == STREAM) && M_AXIS_TREADY;
  assign last_beat = (int'(cnt) == TOTAL_BEATS - 1);

  generate
    if (LAST_PER_ROW != 0) begin : g_last_per_row
      assign tlast_sel = ((int'(cnt) % BEATS_PER_ROW) == BEATS_PER_ROW - 1);
    end else begin : g_last_per_frame
      assign tlast_sel = last_beat;
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      cnt    <= '0;
      done_q <= 1'b0;
    end else begin
      state  <= state_next;
      done_q <= xfer && last_beat;
      if ((state == IDLE) && start) begin
        cnt <= '0;
      end else if (xfer && !last_beat) begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  // Snapshot lets the grid core start the next generation right after start.
  always_ff @(posedge clk) begin
    if ((state == IDLE) && start) begin
      snap <= frame;
    end
  end

  always_comb begin
    state_next    = state;
    busy          = 1'b0;
    done          = done_q;
    M_AXIS_TVALID = 1'b0;
    M_AXIS_TDATA  = '0;
    M_AXIS_TLAST  = 1'b0;
    M_AXIS_TUSER  = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          state_next = STREAM;
        end
      end
      STREAM: begin
        busy          = 1'b1;
        M_AXIS_TVALID = 1'b1;
        M_AXIS_TDATA  = snap[int'(cnt)*DWIDTH +: DWIDTH];
        M_AXIS_TLAST  = tlast_sel;
        M_AXIS_TUSER  = (cnt == '0);
        if (xfer && last_beat) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_grid_axis_streamer.sv
`default_nettype none
// tb_grid_axis_streamer -- scoreboard bench for grid_axis_streamer: default
// configuration (dut_a) and a 2-bit cell, per-row TLAST configuration (dut_b).
module tb_grid_axis_streamer;

  typedef struct packed {
    logic [31:0] data;
    logic        last;
    logic        user;
  } beat_t;

  logic         clk;
  logic         rst;

  logic         a_start, a_busy, a_done, a_tvalid, a_tready, a_tlast, a_tuser;
  logic [1023:0] a_frame;
  logic [31:0]  a_tdata;

  logic         b_start, b_busy, b_done, b_tvalid, b_tready, b_tlast, b_tuser;
  logic [255:0] b_frame;
  logic [15:0]  b_tdata;

  beat_t qa[$];
  beat_t qb[$];
  int    vectors;
  int    miscompares;

  grid_axis_streamer dut_a (
    .clk           (clk),
    .rst           (rst),
    .start         (a_start),
    .frame         (a_frame),
    .busy          (a_busy),
    .done          (a_done),
    .M_AXIS_TVALID (a_tvalid),
    .M_AXIS_TREADY (a_tready),
    .M_AXIS_TDATA  (a_tdata),
    .M_AXIS_TLAST  (a_tlast),
    .M_AXIS_TUSER  (a_tuser)
  );

  grid_axis_streamer #(
    .CELL_WIDTH     (2),
    .WIDTH          (32),
    .HEIGHT         (4),
    .CELLS_PER_BEAT (8),
    .LAST_PER_ROW   (1)
  ) dut_b (
    .clk           (clk),
    .rst           (rst),
    .start         (b_start),
    .frame         (b_frame),
    .busy          (b_busy),
    .done          (b_done),
    .M_AXIS_TVALID (b_tvalid),
    .M_AXIS_TREADY (b_tready),
    .M_AXIS_TDATA  (b_tdata),
    .M_AXIS_TLAST  (b_tlast),
    .M_AXIS_TUSER  (b_tuser)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic test_reset();
    rst = 1'b1;
    a_start = 1'b0; b_start = 1'b0;
    a_tready = 1'b0; b_tready = 1'b0;
    a_frame = '0; b_frame = '0;
    repeat (3) @(negedge clk);
    // start together with reset must be ignored
    a_start = 1'b1;
    @(negedge clk);
    a_start = 1'b0;
    vectors++; if (a_tvalid !== 1'b0) begin miscompares++; $display("FAIL reset_tvalid: got %b expected 0", a_tvalid); end
    vectors++; if (a_busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy: got %b expected 0", a_busy); end
    vectors++; if (a_done !== 1'b0) begin miscompares++; $display("FAIL reset_done: got %b expected 0", a_done); end
    vectors++; if (a_tlast !== 1'b0) begin miscompares++; $display("FAIL reset_tlast: got %b expected 0", a_tlast); end
    vectors++; if (a_tuser !== 1'b0) begin miscompares++; $display("FAIL reset_tuser: got %b expected 0", a_tuser); end
    vectors++; if (a_tdata !== 32'h0) begin miscompares++; $display("FAIL reset_tdata: got %h expected 0", a_tdata); end
    vectors++; if (b_tvalid !== 1'b0) begin miscompares++; $display("FAIL reset_b_tvalid: got %b expected 0", b_tvalid); end
    rst = 1'b0;
    // TREADY while idle does nothing
    a_tready = 1'b1;
    repeat (3) @(negedge clk);
    vectors++; if (a_tvalid !== 1'b0 || a_done !== 1'b0) begin miscompares++; $display("FAIL idle_tready: got tvalid=%b done=%b expected 0 0", a_tvalid, a_done); end
    a_tready = 1'b0;
  endtask

  task automatic test_basic();
    beat_t e;
    int busy_cycles, beats, cyc;
    bit done_seen;
    for (int r = 0; r < 32; r++) a_frame[r*32 +: 32] = 32'h1 << r;
    qa.delete();
    @(negedge clk);
    a_start = 1'b1; a_tready = 1'b1;
    for (int r = 0; r < 32; r++) qa.push_back(beat_t'{data: 32'h1 << r, last: 1'(r == 31), user: 1'(r == 0)});
    @(negedge clk);
    a_start = 1'b0;
    busy_cycles = 0; beats = 0; done_seen = 1'b0;
    for (cyc = 0; cyc < 200 && !done_seen; cyc++) begin
      if (cyc == 0) begin
        vectors++; if (a_tvalid !== 1'b1) begin miscompares++; $display("FAIL basic_latency: got tvalid=%b expected 1", a_tvalid); end
      end
      if (a_busy) busy_cycles++;
      if (a_done) begin
        done_seen = 1'b1;
        vectors++; if (cyc != 32) begin miscompares++; $display("FAIL basic_done_cycle: got %0d expected 32", cyc); end
        vectors++; if (a_tvalid !== 1'b0 || a_tlast !== 1'b0 || a_tuser !== 1'b0) begin miscompares++; $display("FAIL basic_done_outputs: got v=%b l=%b u=%b expected 0 0 0", a_tvalid, a_tlast, a_tuser); end
      end else if (a_tvalid) begin
        if (qa.size() == 0) begin
          vectors++; miscompares++; $display("FAIL basic_extra_beat: got beat %0d expected none", beats);
        end else begin
          e = qa.pop_front();
          vectors++; if (a_tdata !== e.data) begin miscompares++; $display("FAIL basic_tdata beat %0d: got %h expected %h", beats, a_tdata, e.data); end
          vectors++; if (a_tlast !== e.last) begin miscompares++; $display("FAIL basic_tlast beat %0d: got %b expected %b", beats, a_tlast, e.last); end
          vectors++; if (a_tuser !== e.user) begin miscompares++; $display("FAIL basic_tuser beat %0d: got %b expected %b", beats, a_tuser, e.user); end
        end
        beats++;
      end
      @(negedge clk);
    end
    vectors++; if (!done_seen) begin miscompares++; $display("FAIL basic_timeout: got no done expected done"); end
    vectors++; if (busy_cycles != 32) begin miscompares++; $display("FAIL basic_busy_cycles: got %0d expected 32", busy_cycles); end
    vectors++; if (beats != 32) begin miscompares++; $display("FAIL basic_beats: got %0d expected 32", beats); end
  endtask

  task automatic test_random_ready();
    beat_t e, held;
    int beats, cyc;
    bit done_seen, stalled;
    for (int w = 0; w < 32; w++) a_frame[w*32 +: 32] = $urandom();
    qa.delete();
    a_tready = 1'b0;
    @(negedge clk);
    a_start = 1'b1;
    for (int k = 0; k < 32; k++) qa.push_back(beat_t'{data: a_frame[k*32 +: 32], last: 1'(k == 31), user: 1'(k == 0)});
    @(negedge clk);
    a_start = 1'b0;
    beats = 0; done_seen = 1'b0; stalled = 1'b0; held = '0;
    for (cyc = 0; cyc < 2000 && !done_seen; cyc++) begin
      if (a_done) begin
        done_seen = 1'b1;
        vectors++; if (beats != 32) begin miscompares++; $display("FAIL rand_beats: got %0d expected 32", beats); end
      end else begin
        vectors++; if (a_tvalid !== 1'b1) begin miscompares++; $display("FAIL rand_tvalid_drop beat %0d: got %b expected 1", beats, a_tvalid); end
        if (stalled) begin
          vectors++; if ({a_tdata, a_tlast, a_tuser} !== {held.data, held.last, held.user}) begin miscompares++; $display("FAIL rand_stable beat %0d: got %h/%b/%b expected %h/%b/%b", beats, a_tdata, a_tlast, a_tuser, held.data, held.last, held.user); end
        end
        a_tready = 1'($urandom_range(0, 1));
        if (a_tready && a_tvalid) begin
          stalled = 1'b0;
          if (qa.size() == 0) begin
            vectors++; miscompares++; $display("FAIL rand_extra_beat: got beat %0d expected none", beats);
          end else begin
            e = qa.pop_front();
            vectors++; if ({a_tdata, a_tlast, a_tuser} !== {e.data, e.last, e.user}) begin miscompares++; $display("FAIL rand_beat %0d: got %h/%b/%b expected %h/%b/%b", beats, a_tdata, a_tlast, a_tuser, e.data, e.last, e.user); end
          end
          beats++;
        end else begin
          stalled = 1'b1;
          held = beat_t'{data: a_tdata, last: a_tlast, user: a_tuser};
        end
      end
      @(negedge clk);
    end
    vectors++; if (!done_seen) begin miscompares++; $display("FAIL rand_timeout: got no done expected done"); end
    a_tready = 1'b0;
  endtask

  task automatic test_packed();
    beat_t e;
    int beats, cyc;
    bit done_seen;
    for (int n = 0; n < 128; n++) b_frame[n*2 +: 2] = 2'(n % 4);
    qb.delete();
    @(negedge clk);
    b_start = 1'b1; b_tready = 1'b1;
    for (int k = 0; k < 16; k++) qb.push_back(beat_t'{data: 32'h0000_E4E4, last: 1'((k % 4) == 3), user: 1'(k == 0)});
    @(negedge clk);
    b_start = 1'b0;
    beats = 0; done_seen = 1'b0;
    for (cyc = 0; cyc < 200 && !done_seen; cyc++) begin
      if (b_done) begin
        done_seen = 1'b1;
        vectors++; if (cyc != 16 || beats != 16) begin miscompares++; $display("FAIL packed_done: got cycle %0d beats %0d expected 16 16", cyc, beats); end
      end else if (b_tvalid) begin
        if (qb.size() == 0) begin
          vectors++; miscompares++; $display("FAIL packed_extra_beat: got beat %0d expected none", beats);
        end else begin
          e = qb.pop_front();
          vectors++; if ({16'h0, b_tdata} !== e.data) begin miscompares++; $display("FAIL packed_tdata beat %0d: got %h expected %h", beats, b_tdata, e.data); end
          vectors++; if (b_tlast !== e.last) begin miscompares++; $display("FAIL packed_tlast beat %0d: got %b expected %b", beats, b_tlast, e.last); end
          vectors++; if (b_tuser !== e.user) begin miscompares++; $display("FAIL packed_tuser beat %0d: got %b expected %b", beats, b_tuser, e.user); end
        end
        beats++;
      end
      @(negedge clk);
    end
    vectors++; if (!done_seen) begin miscompares++; $display("FAIL packed_timeout: got no done expected done"); end
    b_tready = 1'b0;
  endtask

  task automatic test_snapshot();
    beat_t e;
    int beats, cyc, dones;
    bit done_seen;
    for (int w = 0; w < 32; w++) a_frame[w*32 +: 32] = $urandom() & ~(32'h1 << w);
    qa.delete();
    @(negedge clk);
    a_start = 1'b1; a_tready = 1'b1;
    for (int k = 0; k < 32; k++) qa.push_back(beat_t'{data: a_frame[k*32 +: 32], last: 1'(k == 31), user: 1'(k == 0)});
    @(negedge clk);
    beats = 0; dones = 0; done_seen = 1'b0;
    for (cyc = 0; cyc < 200 && !done_seen; cyc++) begin
      if (cyc == 0) begin
        a_frame = '1;
        a_start = 1'b1;
      end else if (cyc == 3) begin
        a_start = 1'b0;
      end
      if (a_done) begin
        done_seen = 1'b1;
        dones++;
      end else if (a_tvalid) begin
        if (qa.size() == 0) begin
          vectors++; miscompares++; $display("FAIL snap_extra_beat: got beat %0d expected none", beats);
        end else begin
          e = qa.pop_front();
          vectors++; if ({a_tdata, a_tlast, a_tuser} !== {e.data, e.last, e.user}) begin miscompares++; $display("FAIL snap_beat %0d: got %h/%b/%b expected %h/%b/%b", beats, a_tdata, a_tlast, a_tuser, e.data, e.last, e.user); end
        end
        beats++;
      end
      @(negedge clk);
    end
    a_start = 1'b0;
    vectors++; if (!done_seen || beats != 32) begin miscompares++; $display("FAIL snap_frame: got done=%b beats=%0d expected 1 32", done_seen, beats); end
    repeat (6) begin
      if (a_done) dones++;
      vectors++; if (a_tvalid !== 1'b0) begin miscompares++; $display("FAIL snap_start_queued: got tvalid=%b expected 0", a_tvalid); end
      @(negedge clk);
    end
    vectors++; if (dones != 1) begin miscompares++; $display("FAIL snap_done_count: got %0d expected 1", dones); end
    a_tready = 1'b0;
  endtask

  task automatic test_reset_midframe();
    beat_t e;
    int beats, cyc, lasts;
    bit done_seen;
    for (int w = 0; w < 32; w++) a_frame[w*32 +: 32] = 32'hA500_0000 | 32'(w);
    qa.delete();
    @(negedge clk);
    a_start = 1'b1; a_tready = 1'b1;
    @(negedge clk);
    a_start = 1'b0;
    lasts = 0;
    for (cyc = 0; cyc < 11; cyc++) begin
      if (a_tvalid && a_tlast) lasts++;
      if (cyc == 10) begin
        vectors++; if (a_tdata !== 32'hA500_000A) begin miscompares++; $display("FAIL rstmid_beat10: got %h expected a500000a", a_tdata); end
        rst = 1'b1;
      end
      @(negedge clk);
    end
    rst = 1'b0;
    vectors++; if ({a_tvalid, a_busy, a_done, a_tlast, a_tuser} !== 5'b0) begin miscompares++; $display("FAIL rstmid_outputs: got v=%b b=%b d=%b l=%b u=%b expected all 0", a_tvalid, a_busy, a_done, a_tlast, a_tuser); end
    vectors++; if (lasts != 0) begin miscompares++; $display("FAIL rstmid_tlast_seen: got %0d expected 0", lasts); end
    a_start = 1'b1;
    for (int k = 0; k < 32; k++) qa.push_back(beat_t'{data: 32'hA500_0000 | 32'(k), last: 1'(k == 31), user: 1'(k == 0)});
    @(negedge clk);
    a_start = 1'b0;
    beats = 0; done_seen = 1'b0;
    for (cyc = 0; cyc < 200 && !done_seen; cyc++) begin
      if (a_done) begin
        done_seen = 1'b1;
      end else if (a_tvalid) begin
        if (qa.size() == 0) begin
          vectors++; miscompares++; $display("FAIL rstmid_extra_beat: got beat %0d expected none", beats);
        end else begin
          e = qa.pop_front();
          vectors++; if ({a_tdata, a_tlast, a_tuser} !== {e.data, e.last, e.user}) begin miscompares++; $display("FAIL rstmid_beat %0d: got %h/%b/%b expected %h/%b/%b", beats, a_tdata, a_tlast, a_tuser, e.data, e.last, e.user); end
        end
        beats++;
      end
      @(negedge clk);
    end
    vectors++; if (!done_seen || beats != 32) begin miscompares++; $display("FAIL rstmid_restart: got done=%b beats=%0d expected 1 32", done_seen, beats); end
    a_tready = 1'b0;
  endtask

  task automatic test_back_to_back();
    beat_t e;
    logic [1023:0] frame_b;
    int beats, cyc, dones;
    for (int w = 0; w < 32; w++) a_frame[w*32 +: 32] = $urandom();
    for (int w = 0; w < 32; w++) frame_b[w*32 +: 32] = $urandom();
    qa.delete();
    @(negedge clk);
    a_start = 1'b1; a_tready = 1'b1;
    for (int k = 0; k < 32; k++) qa.push_back(beat_t'{data: a_frame[k*32 +: 32], last: 1'(k == 31), user: 1'(k == 0)});
    @(negedge clk);
    beats = 0; dones = 0;
    for (cyc = 0; cyc < 300 && dones < 2; cyc++) begin
      a_start = 1'b0;
      if (cyc == 33) begin
        vectors++; if (a_tvalid !== 1'b1 || a_tuser !== 1'b1) begin miscompares++; $display("FAIL b2b_second_start: got v=%b u=%b expected 1 1", a_tvalid, a_tuser); end
      end
      if (a_done) begin
        dones++;
        if (dones == 1) begin
          vectors++; if (cyc != 32) begin miscompares++; $display("FAIL b2b_done_a: got cycle %0d expected 32", cyc); end
          a_frame = frame_b;
          a_start = 1'b1;
          for (int k = 0; k < 32; k++) qa.push_back(beat_t'{data: frame_b[k*32 +: 32], last: 1'(k == 31), user: 1'(k == 0)});
        end else begin
          vectors++; if (cyc + 1 != 66) begin miscompares++; $display("FAIL b2b_span: got %0d cycles expected 66", cyc + 1); end
        end
      end else if (a_tvalid) begin
        if (qa.size() == 0) begin
          vectors++; miscompares++; $display("FAIL b2b_extra_beat: got beat %0d expected none", beats);
        end else begin
          e = qa.pop_front();
          vectors++; if ({a_tdata, a_tlast, a_tuser} !== {e.data, e.last, e.user}) begin miscompares++; $display("FAIL b2b_beat %0d: got %h/%b/%b expected %h/%b/%b", beats, a_tdata, a_tlast, a_tuser, e.data, e.last, e.user); end
        end
        beats++;
      end
      @(negedge clk);
    end
    a_start = 1'b0;
    vectors++; if (dones != 2 || beats != 64) begin miscompares++; $display("FAIL b2b_totals: got dones=%0d beats=%0d expected 2 64", dones, beats); end
    a_tready = 1'b0;
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    test_reset();
    test_basic();
    test_random_ready();
    test_packed();
    test_snapshot();
    test_reset_midframe();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
